// File: rtl/cordic_rotation.sv
// cordic_rotation: iterative rotation-mode CORDIC, one micro-rotation per clock.
// Define CORDIC_GAIN_COMP_EN to add a COMP state that removes the CORDIC gain.
module cordic_rotation #(
    parameter int WORD_WIDTH = 16,
    parameter int ITERATIONS = 14
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic signed [WORD_WIDTH-1:0] x_in,
    input  logic signed [WORD_WIDTH-1:0] y_in,
    input  logic signed [WORD_WIDTH-1:0] z_in,
    output logic                         busy,
    output logic                         done,
    output logic signed [WORD_WIDTH+1:0] x_out,
    output logic signed [WORD_WIDTH+1:0] y_out
);
    localparam int OW = WORD_WIDTH + 2;
    localparam logic [1:0] IDLE = 2'd0, ITER = 2'd1, DONE = 2'd3;
`ifdef CORDIC_GAIN_COMP_EN
    localparam logic [1:0] COMP = 2'd2;
`endif
    localparam logic signed [WORD_WIDTH-1:0] QTR = {2'b01, {(WORD_WIDTH-2){1'b0}}};
    // atan(2^-i) with 2^31 = pi; the top WORD_WIDTH bits are used
    localparam logic [31:0] ATAN [32] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2F9, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
        32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
        32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
        32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
    };

    logic [1:0] state;
    logic [4:0] cnt;
    logic signed [OW-1:0] x, y, xe, ye, x0, y0, x_n, y_n;
    logic signed [WORD_WIDTH-1:0] z, z0, z_n, atan;
    logic d, last;

    always_comb begin
        xe = {{2{x_in[WORD_WIDTH-1]}}, x_in};
        ye = {{2{y_in[WORD_WIDTH-1]}}, y_in};
        x0 = z_in > QTR ? -ye : z_in < -QTR ? ye : xe;
        y0 = z_in > QTR ? xe : z_in < -QTR ? -xe : ye;
        z0 = z_in > QTR ? z_in - QTR : z_in < -QTR ? z_in + QTR : z_in;
        atan = ATAN[cnt][31 -: WORD_WIDTH];
        d = ~z[WORD_WIDTH-1];
        x_n = d ? x - (y >>> cnt) : x + (y >>> cnt);
        y_n = d ? y + (x >>> cnt) : y - (x >>> cnt);
        z_n = d ? z - atan : z + atan;
        last = cnt == 5'(ITERATIONS - 1);
    end

`ifdef CORDIC_GAIN_COMP_EN
    // v * 19898 / 2^15, rounded to nearest with ties away from zero
    function automatic logic signed [OW-1:0] inv_gain(input logic signed [OW-1:0] v);
        logic signed [OW+15:0] ve, p, r;
        ve = {{16{v[OW-1]}}, v};
        p = (ve <<< 14) + (ve <<< 11) + (ve <<< 10) + (ve <<< 8) + (ve <<< 7)
          + (ve <<< 5) + (ve <<< 4) + (ve <<< 3) + (ve <<< 1);
        r = p + (p[OW+15] ? (OW+16)'(16383) : (OW+16)'(16384));
        return OW'(r >>> 15);
    endfunction
    assign busy = state == ITER || state == COMP;
`else
    assign busy = state == ITER;
`endif
    assign done = state == DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            x <= '0;
            y <= '0;
            z <= '0;
            x_out <= '0;
            y_out <= '0;
        end else begin
            case (state)
                ITER: begin
                    x <= x_n;
                    y <= y_n;
                    z <= z_n;
                    cnt <= cnt + 5'd1;
                    if (last) begin
`ifdef CORDIC_GAIN_COMP_EN
                        state <= COMP;
`else
                        state <= DONE;
                        x_out <= x_n;
                        y_out <= y_n;
`endif
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                COMP: begin
                    state <= DONE;
                    x_out <= inv_gain(x);
                    y_out <= inv_gain(y);
                end
`endif
                default: begin
                    if (start) begin
                        state <= ITER;
                        cnt <= '0;
                        x <= x0;
                        y <= y0;
                        z <= z0;
                    end else if (state == DONE) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_rotation.sv
// tb_cordic_rotation: randomized and directed checks of cordic_rotation against
// an arithmetic reference model and an ideal floating-point rotation.
module tb_cordic_rotation;
    localparam int WW = 16, IT = 14, OW = WW + 2;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = IT + 2;
`else
    localparam int LAT = IT + 1;
`endif
    localparam real PI = 3.14159265358979323846;

    logic clk = 0, rst = 1, start = 0;
    logic signed [WW-1:0] x_in = '0, y_in = '0, z_in = '0;
    logic busy, done;
    logic signed [OW-1:0] x_out, y_out;
    int checks = 0, failures = 0;
    longint at [IT];
    real gain;

    always #5 clk = ~clk;

    cordic_rotation #(.WORD_WIDTH(WW), .ITERATIONS(IT)) dut (
        .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .busy(busy), .done(done), .x_out(x_out), .y_out(y_out)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic longint unscale(input longint v);
        return v >= 0 ? (v * 19898 + 16384) >>> 15 : -((-v * 19898 + 16384) >>> 15);
    endfunction

    function automatic void model(input longint xi, yi, zi, output longint xo, yo);
        longint x, y, z, t, q;
        q = longint'(1) << (WW - 2);
        if (zi > q) begin x = -yi; y = xi; z = zi - q; end
        else if (zi < -q) begin x = yi; y = -xi; z = zi + q; end
        else begin x = xi; y = yi; z = zi; end
        for (int i = 0; i < IT; i++) begin
            t = x;
            if (z >= 0) begin x = x - (y >>> i); y = y + (t >>> i); z = z - at[i]; end
            else begin x = x + (y >>> i); y = y - (t >>> i); z = z + at[i]; end
        end
`ifdef CORDIC_GAIN_COMP_EN
        xo = unscale(x);
        yo = unscale(y);
`else
        xo = x;
        yo = y;
`endif
    endfunction

    task automatic launch(input logic signed [WW-1:0] x, y, z);
        x_in = x; y_in = y; z_in = z; start = 1;
        @(posedge clk); #1;
        start = 0; x_in = WW'($urandom); y_in = WW'($urandom); z_in = WW'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 60) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic check_result(input string tag, input longint x, y, z, input int tol);
        longint ex, ey;
        real a, ix, iy;
        model(x, y, z, ex, ey);
        check({tag, "_x"}, x_out, ex);
        check({tag, "_y"}, y_out, ey);
        if (tol > 0) begin
            a = $itor(z) * PI / (2.0 ** (WW - 1));
            ix = gain * ($itor(x) * $cos(a) - $itor(y) * $sin(a));
            iy = gain * ($itor(y) * $cos(a) + $itor(x) * $sin(a));
            check({tag, "_x_near"}, longint'($itor(x_out) - ix <= tol && ix - $itor(x_out) <= tol), 1);
            check({tag, "_y_near"}, longint'($itor(y_out) - iy <= tol && iy - $itor(y_out) <= tol), 1);
        end
    endtask

    task automatic op(input string tag, input logic signed [WW-1:0] x, y, z, input int tol);
        int lat;
        launch(x, y, z);
        check({tag, "_busy"}, longint'(busy), 1);
        check({tag, "_nodone"}, longint'(done), 0);
        wait_done(lat);
        check({tag, "_lat"}, lat, LAT);
        check_result(tag, x, y, z, tol);
    endtask

    initial begin
        int lat, seen, dlat;
        logic signed [WW-1:0] rx, ry, rz;
        gain = 1.0;
`ifndef CORDIC_GAIN_COMP_EN
        for (int i = 0; i < IT; i++) gain = gain * $sqrt(1.0 + 2.0 ** (-2 * i));
`endif
        for (int i = 0; i < IT; i++)
            at[i] = longint'($rtoi($atan(2.0 ** (-i)) / PI * (2.0 ** 31) + 0.5)) >>> (32 - WW);

        repeat (3) @(posedge clk);
        #1 rst = 0;
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_x", x_out, 0);
        check("rst_y", y_out, 0);

        op("z0", 16'sd10000, 16'sd0, 16'sd0, 12);
        op("z90", 16'sd10000, 16'sd0, 16'sd16384, 12);
        op("z45", 16'sd10000, 16'sd0, 16'sd8192, 12);
        op("z180", 16'sd10000, 16'sd0, -16'sd32768, 12);
        op("xmin", -16'sd32768, 16'sd0, 16'sd0, 24);
        op("zm90", 16'sd7000, -16'sd3000, -16'sd16384, 12);
        op("z91", 16'sd7000, 16'sd3000, 16'sd16385, 12);

        // extra starts while busy must be ignored
        repeat (2) @(posedge clk);
        #1;
        launch(16'sd12000, 16'sd5000, 16'sd3000);
        lat = 1; seen = 0; dlat = 0;
        while (lat < LAT + 4) begin
            if (lat == 3 || lat == 8) begin
                x_in = 16'sd100; y_in = -16'sd200; z_in = 16'sd20000; start = 1;
            end
            @(posedge clk); #1;
            start = 0;
            lat++;
            if (done) begin seen++; if (seen == 1) dlat = lat; end
        end
        check("ign_count", seen, 1);
        check("ign_lat", dlat, LAT);
        check_result("ign", 12000, 5000, 3000, 0);

        op("b2b_a", 16'sd9000, 16'sd9000, -16'sd5000, 12);
        op("b2b_b", -16'sd4000, 16'sd11000, 16'sd25000, 12);

        // reset mid-operation aborts without a done
        repeat (3) @(posedge clk);
        #1;
        launch(16'sd10000, 16'sd0, 16'sd0);
        repeat (5) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        check("abort_busy", longint'(busy), 0);
        check("abort_done", longint'(done), 0);
        check("abort_x", x_out, 0);
        check("abort_y", y_out, 0);
        seen = 0;
        repeat (30) begin @(posedge clk); #1; if (done) seen++; end
        check("abort_nodone", seen, 0);
        op("fresh", 16'sd10000, 16'sd0, 16'sd0, 12);

        // reset wins over start
        repeat (2) @(posedge clk);
        #1 rst = 1; start = 1;
        @(posedge clk); #1 rst = 0; start = 0;
        @(posedge clk); #1;
        check("rst_start_busy", longint'(busy), 0);

        for (int n = 0; n < 40; n++) begin
            rx = WW'($urandom); ry = WW'($urandom); rz = WW'($urandom);
            if (n % 10 == 3) rz = -16'sd32768;
            if (n % 10 == 7) rx = -16'sd32768;
            launch(rx, ry, rz);
            wait_done(lat);
            check("rnd_lat", lat, LAT);
            check_result("rnd", rx, ry, rz, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cordic_rotation.md
# cordic_rotation

Iterative CORDIC engine in rotation mode: rotates an input vector (x, y) by a signed binary angle z and returns the rotated vector. It is the inverse-direction counterpart of the vectoring-mode datapath: vectoring takes (x, y) to (magnitude, angle), and this block takes a vector plus an angle back to Cartesian coordinates. It shares the same signed word format and binary-angle convention, so a vectoring result can be fed straight back in. One micro-rotation is computed per clock under a start/done handshake.

## Interface
- WORD_WIDTH, 16, width of x_in/y_in/z_in; legal range 12..24.
- ITERATIONS, 14, number of micro-rotations; legal range 8..WORD_WIDTH-1.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when the block is ready (IDLE or DONE).
- x_in  in  WORD_WIDTH  signed two's-complement x.
- y_in  in  WORD_WIDTH  signed two's-complement y.
- z_in  in  WORD_WIDTH  signed binary angle; 2^(WORD_WIDTH-1) represents π, so 16384 = +90° when WORD_WIDTH=16.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; outputs are valid from this cycle onward.
- x_out  out  WORD_WIDTH+2  signed rotated x.
- y_out  out  WORD_WIDTH+2  signed rotated y.

## Operation
- FSM states: IDLE, ITER, COMP (exists only with the macro), DONE.
- IDLE/DONE with start=1: capture the inputs, sign-extended to WORD_WIDTH+2 bits, and apply the quadrant pre-rotation. Next state is ITER with i=0.
- Pre-rotation is based on z_in:
  - |z| ≤ 90°: x0=x, y0=y, z0=z.
  - z > 90°: x0=-y, y0=x, z0=z-90°.
  - z < -90°: x0=y, y0=-x, z0=z+90°.
  - The z arithmetic wraps modulo 2^WORD_WIDTH.
  - -2^(WORD_WIDTH-1) (-180°) takes the z < -90° branch.
- ITER step i: d = +1 if z ≥ 0, otherwise -1.
  - x ← x - d·(y>>>i)
  - y ← y + d·(x>>>i)
  - z ← z - d·atan_i
  - x and y update from the same old values. >>> is an arithmetic shift.
- atan_i = round(atan(2^-i)/π · 2^31) >> (32-WORD_WIDTH). The table is a 32-bit constant ROM indexed by the counter.
- When i = ITERATIONS-1 completes, go to COMP if the macro is defined, otherwise to DONE.
- DONE: done=1 and busy=0. With start=0 the next state is IDLE.
- x_out/y_out hold their last result until the next completion.
- The most negative input needs no special case, because the 2 guard bits absorb both the negation and the gain.

## Timing
- Reset values: busy=0, done=0, x_out=0, y_out=0, FSM=IDLE, counter=0.
- Latency: start sampled at edge T gives done high in cycle T+ITERATIONS+1, or T+ITERATIONS+2 with the macro.
- busy rises the cycle after start is accepted and falls in the done cycle.
- start asserted while busy is ignored; there is no queueing.
- start asserted in the DONE cycle is accepted, which allows back-to-back throughput of one result per ITERATIONS+1 cycles.
- rst at any point, including mid-ITER: the next cycle shows reset values, and no done is produced for the aborted operation.
- rst together with start: rst wins.
- Inputs only need to be stable in the accepting cycle.

## Configuration
- CORDIC_GAIN_COMP_EN defined:
  - The COMP state multiplies x and y by 1/K, using the Q1.15 constant 19898 (0x4DBA) built from a shift-add network.
  - Results are rounded to nearest, ties away from zero.
  - Latency increases by 1 cycle.
  - Outputs are true-magnitude rotations.
- Not defined:
  - No COMP state and no multiplier logic.
  - Outputs carry the CORDIC gain K ≈ 1.6468.

## Test plan
All cases use WORD_WIDTH=16 and ITERATIONS=14, with no macro unless stated.
- x=10000, y=0, z=0, start → done exactly 15 cycles after the start edge; x_out=16468±4, y_out=0±4.
- x=10000, y=0, z=16384 (+90°) → x_out=0±4, y_out=16468±4. Repeat with z=8192 (+45°) → x_out=y_out=11645±4.
- x=10000, y=0, z=-32768 (-180°) → x_out=-16468±4, y_out=0±4. Repeat with x=-32768, y=0, z=0 → x_out=-53962±8, with no overflow.
- Start, then pulse start again at cycles 3 and 8 → a single done at cycle 15, with results from the first operand set. Start again in the DONE cycle → second done 15 cycles later.
- Start, then rst at cycle 6 → next cycle shows busy=0, done=0, x_out=y_out=0, and no done within 30 cycles. A fresh start then completes normally.
- CORDIC_GAIN_COMP_EN defined: x=10000, y=0, z=0 → done at cycle 16, x_out=10000±4, y_out=0±4.
